// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch sequencer and
// the instruction memory.
//   imem_req  : fetch request, driven by the sequencer
//   imem_addr : word-aligned fetch address, stable while imem_req is high
//   imem_ack  : memory has data for the outstanding request
//   imem_data : instruction word, valid together with imem_ack
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer. Owns the program counter, issues requests to
// instruction memory, buffers a fetched word while the front end is stalled
// and discards responses made stale by a branch or jump redirect.
// Ports:
//   clock, rst            : clock and synchronous active-high reset
//   stall                 : front-end stall, blocks delivery to IF/ID
//   br_taken, br_target   : taken branch from EX/MEM (highest priority)
//   jmp, jmp_target       : jump from decode
//   imem                  : instruction-memory bus (master side)
//   inst_valid            : one-cycle pulse per delivered instruction
//   inst, inst_pc         : delivered word and its PC, held when not valid
//   pc                    : current fetch PC
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [31:0]        br_target,
    input  logic               jmp,
    input  logic [31:0]        jmp_target,
    fetch_ctrl_if.master       imem,
    output logic               inst_valid,
    output logic [31:0]        inst,
    output logic [31:0]        inst_pc,
    output logic [31:0]        pc
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] addr_r;
    logic        req_r;
    logic        inst_valid_r;
    logic [31:0] inst_r;
    logic [31:0] inst_pc_r;
    logic [31:0] buf_inst_r;
    logic [31:0] buf_pc_r;

    logic        redirect_s;
    logic [31:0] target_s;
    logic        ack_s;
    logic [31:0] pc_inc_s;

    // Redirect selection (branch beats jump), qualified ack and sequential PC.
    always_comb begin
        redirect_s = br_taken | jmp;
        target_s   = (br_taken ? br_target : jmp_target) & 32'hFFFF_FFFC;
        // An ack is meaningful only while a request is actually outstanding.
        ack_s      = imem.imem_ack & req_r;
        pc_inc_s   = pc_r + 32'd4;
    end

    // Fetch state machine with registered PC, request and delivery outputs.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_r      <= S_FETCH;
            pc_r         <= RESET_PC;
            addr_r       <= RESET_PC;
            req_r        <= 1'b0;
            inst_valid_r <= 1'b0;
            inst_r       <= 32'd0;
            inst_pc_r    <= 32'd0;
            buf_inst_r   <= 32'd0;
            buf_pc_r     <= 32'd0;
        end else begin
            inst_valid_r <= 1'b0;
            case (state_r)
                S_FETCH: begin
                    if (!req_r) begin
                        // Leaving reset: nothing outstanding, start a request.
                        req_r <= 1'b1;
                        if (redirect_s) begin
                            pc_r   <= target_s;
                            addr_r <= target_s;
                        end else begin
                            addr_r <= pc_r;
                        end
                    end else if (redirect_s) begin
                        pc_r <= target_s;
                        if (ack_s) begin
                            addr_r <= target_s;
                        end else begin
                            // Keep addr_r stable until the stale ack arrives.
                            state_r <= S_DROP;
                        end
                    end else if (ack_s) begin
                        pc_r <= pc_inc_s;
                        if (stall) begin
                            buf_inst_r <= imem.imem_data;
                            buf_pc_r   <= pc_r;
                            req_r      <= 1'b0;
                            state_r    <= S_HOLD;
                        end else begin
                            inst_valid_r <= 1'b1;
                            inst_r       <= imem.imem_data;
                            inst_pc_r    <= pc_r;
                            addr_r       <= pc_inc_s;
                        end
                    end else begin
                        state_r <= S_FETCH;
                    end
                end
                S_HOLD: begin
                    if (redirect_s) begin
                        pc_r    <= target_s;
                        addr_r  <= target_s;
                        req_r   <= 1'b1;
                        state_r <= S_FETCH;
                    end else if (!stall) begin
                        inst_valid_r <= 1'b1;
                        inst_r       <= buf_inst_r;
                        inst_pc_r    <= buf_pc_r;
                        addr_r       <= pc_r;
                        req_r        <= 1'b1;
                        state_r      <= S_FETCH;
                    end else begin
                        state_r <= S_HOLD;
                    end
                end
                S_DROP: begin
                    if (redirect_s) begin
                        pc_r <= target_s;
                    end else begin
                        pc_r <= pc_r;
                    end
                    if (ack_s) begin
                        // Stale word is dropped; refetch from the latest PC.
                        addr_r  <= redirect_s ? target_s : pc_r;
                        state_r <= S_FETCH;
                    end else begin
                        state_r <= S_DROP;
                    end
                end
                default: begin
                    state_r <= S_FETCH;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_r;
    assign imem.imem_addr = addr_r;
    assign inst_valid     = inst_valid_r;
    assign inst           = inst_r;
    assign inst_pc        = inst_pc_r;
    assign pc             = pc_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: each step drives inputs, advances one clock
// edge and checks outputs 1 time unit later against hand-computed values.
module tb_fetch_ctrl;

    logic        clock = 1'b0;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        ack;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] pc;

    int errors = 0;
    int checks = 0;

    fetch_ctrl_if bus ();

    assign bus.imem_ack  = ack;
    // Memory content: each word is its address XOR a fixed tag.
    assign bus.imem_data = bus.imem_addr ^ 32'hDEAD_0000;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clock      (clock),
        .rst        (rst),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp        (jmp),
        .jmp_target (jmp_target),
        .imem       (bus),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .pc         (pc)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    initial begin
        rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 32'd0;
        jmp = 1'b0; jmp_target = 32'd0; ack = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_pc", pc, 32'd0);

        // Zero-wait memory: one instruction per cycle
        rst = 1'b0; ack = 1'b1;
        tick();
        chk("zw_req1", {31'd0, bus.imem_req}, 32'd1);
        chk("zw_addr1", bus.imem_addr, 32'h0);
        chk("zw_valid1", {31'd0, inst_valid}, 32'd0);
        tick();
        chk("zw_valid2", {31'd0, inst_valid}, 32'd1);
        chk("zw_ipc2", inst_pc, 32'h0);
        chk("zw_inst2", inst, word(32'h0));
        chk("zw_addr2", bus.imem_addr, 32'h4);
        tick();
        chk("zw_valid3", {31'd0, inst_valid}, 32'd1);
        chk("zw_ipc3", inst_pc, 32'h4);
        chk("zw_addr3", bus.imem_addr, 32'h8);
        tick();
        chk("zw_ipc4", inst_pc, 32'h8);
        chk("zw_req4", {31'd0, bus.imem_req}, 32'd1);

        // Two-cycle memory latency, restart from reset
        rst = 1'b1; ack = 1'b0;
        tick();
        rst = 1'b0;
        tick();                                  // cycle A
        chk("lat_addrA", bus.imem_addr, 32'h0);
        tick();                                  // cycle B
        chk("lat_addrB", bus.imem_addr, 32'h0);
        chk("lat_validB", {31'd0, inst_valid}, 32'd0);
        tick();                                  // cycle C
        chk("lat_addrC", bus.imem_addr, 32'h0);
        ack = 1'b1;
        tick();                                  // cycle D
        chk("lat_validD", {31'd0, inst_valid}, 32'd1);
        chk("lat_ipcD", inst_pc, 32'h0);
        chk("lat_addrD", bus.imem_addr, 32'h4);
        ack = 1'b0;
        tick();
        chk("lat_validE", {31'd0, inst_valid}, 32'd0);
        chk("lat_hold_ipcE", inst_pc, 32'h0);
        tick();
        ack = 1'b1;
        tick();                                  // cycle G
        chk("lat_validG", {31'd0, inst_valid}, 32'd1);
        chk("lat_ipcG", inst_pc, 32'h4);
        chk("lat_addrG", bus.imem_addr, 32'h8);

        // Stall on ack for 0x8, held for three edges; acks in HOLD ignored
        stall = 1'b1; ack = 1'b1;
        tick();
        chk("st_req_hold", {31'd0, bus.imem_req}, 32'd0);
        chk("st_valid1", {31'd0, inst_valid}, 32'd0);
        chk("st_pc", pc, 32'hC);
        tick();
        chk("st_valid2", {31'd0, inst_valid}, 32'd0);
        ack = 1'b0;
        tick();
        chk("st_valid3", {31'd0, inst_valid}, 32'd0);
        chk("st_req3", {31'd0, bus.imem_req}, 32'd0);
        stall = 1'b0;
        tick();
        chk("st_rel_valid", {31'd0, inst_valid}, 32'd1);
        chk("st_rel_ipc", inst_pc, 32'h8);
        chk("st_rel_inst", inst, word(32'h8));
        chk("st_rel_addr", bus.imem_addr, 32'hC);
        chk("st_rel_req", {31'd0, bus.imem_req}, 32'd1);

        // Branch while 0x10 outstanding, ack two cycles later
        ack = 1'b1;
        tick();
        chk("br_addr10", bus.imem_addr, 32'h10);
        ack = 1'b0; br_taken = 1'b1; br_target = 32'h100;
        tick();
        br_taken = 1'b0;
        chk("br_drop_addr", bus.imem_addr, 32'h10);
        chk("br_drop_pc", pc, 32'h100);
        chk("br_drop_req", {31'd0, bus.imem_req}, 32'd1);
        chk("br_drop_valid", {31'd0, inst_valid}, 32'd0);
        chk("br_hold_ipc", inst_pc, 32'hC);
        tick();
        chk("br_drop_addr2", bus.imem_addr, 32'h10);
        ack = 1'b1;
        tick();
        chk("br_stale_valid", {31'd0, inst_valid}, 32'd0);
        chk("br_new_addr", bus.imem_addr, 32'h100);
        tick();
        chk("br_first_valid", {31'd0, inst_valid}, 32'd1);
        chk("br_first_ipc", inst_pc, 32'h100);

        // Branch and jump together: branch wins; then jump alone, aligned
        br_taken = 1'b1; br_target = 32'h200; jmp = 1'b1; jmp_target = 32'h303;
        tick();
        chk("pri_addr", bus.imem_addr, 32'h200);
        chk("pri_valid", {31'd0, inst_valid}, 32'd0);
        br_taken = 1'b0;
        tick();
        chk("jmp_addr", bus.imem_addr, 32'h300);
        chk("jmp_pc", pc, 32'h300);
        chk("jmp_valid", {31'd0, inst_valid}, 32'd0);
        jmp = 1'b0;
        tick();
        chk("jmp_ipc", inst_pc, 32'h300);

        // Redirect in HOLD overrides stall
        stall = 1'b1;
        tick();
        chk("hr_req", {31'd0, bus.imem_req}, 32'd0);
        jmp = 1'b1; jmp_target = 32'h400;
        tick();
        chk("hr_addr", bus.imem_addr, 32'h400);
        chk("hr_req2", {31'd0, bus.imem_req}, 32'd1);
        chk("hr_valid", {31'd0, inst_valid}, 32'd0);
        jmp = 1'b0; stall = 1'b0;
        tick();
        chk("hr_ipc", inst_pc, 32'h400);

        // Wrap at top of address space
        jmp = 1'b1; jmp_target = 32'hFFFF_FFFC;
        tick();
        chk("wr_addr", bus.imem_addr, 32'hFFFF_FFFC);
        jmp = 1'b0;
        tick();
        chk("wr_ipc", inst_pc, 32'hFFFF_FFFC);
        chk("wr_next_addr", bus.imem_addr, 32'h0);
        chk("wr_pc", pc, 32'h0);

        // Reset while in DROP
        ack = 1'b0; br_taken = 1'b1; br_target = 32'h500;
        tick();
        chk("rd_pc", pc, 32'h500);
        br_taken = 1'b0; rst = 1'b1;
        tick();
        chk("rd_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rd_pc_rst", pc, 32'h0);
        chk("rd_valid", {31'd0, inst_valid}, 32'd0);
        chk("rd_ipc", inst_pc, 32'h0);
        rst = 1'b0;
        tick();
        chk("rd_restart_req", {31'd0, bus.imem_req}, 32'd1);
        chk("rd_restart_addr", bus.imem_addr, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
